// File: rtl/prog_loader_pkg.sv
// Shared types and default sizes for the program loader.
// PROG_LOADER_CHECKSUM_EN adds the CHECK state used for trailer verification.
package prog_loader_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;
  localparam int CKSUM_W    = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GETLEN  = 3'd1,
    GETBYTE = 3'd2,
    SETADDR = 3'd3,
    WRITE   = 3'd4,
`ifdef PROG_LOADER_CHECKSUM_EN
    CHECK   = 3'd5,
`endif
    DONE    = 3'd6
  } state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream, RAM-programming and status signals of the program loader.
// Handshake: a byte moves on a rising Clock edge where InValid=1 and InReady=1; the source holds InData until then.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              Start;
  logic              InValid;
  logic [DATA_W-1:0] InData;
  logic              InReady;
  logic              programEn;
  logic [ADDR_W-1:0] AddrSel;
  logic              Addrload;
  logic              PRload;
  logic [DATA_W-1:0] Din;
  logic              Busy;
  logic              Done;
  logic              Error;

  modport loader (
    input  Start, InValid, InData,
    output InReady, programEn, AddrSel, Addrload, PRload, Din, Busy, Done, Error
  );

  modport host (
    output Start, InValid, InData,
    input  InReady, programEn, AddrSel, Addrload, PRload, Din, Busy, Done, Error
  );
endinterface

// File: rtl/prog_loader_cksum.sv
// Modulo-256 running sum of the data bytes of one load (built only with PROG_LOADER_CHECKSUM_EN).
module prog_loader_cksum
  import prog_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               add_i,
  input  logic [DATA_W-1:0]  data_i,
  output logic [CKSUM_W-1:0] sum_o
);

  logic [CKSUM_W-1:0] sum_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= '0;
    end else if (clr_i) begin
      sum_q <= '0;
    end else if (add_i) begin
      sum_q <= sum_q + CKSUM_W'(data_i);
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed byte sequence into program RAM via Addrload/PRload strobes.
// Optional trailer checksum when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic           Clock,
  input  logic           Reset,
  prog_loader_if.loader  bus,
  output state_e         dbg_state_o
);

  localparam logic [ADDR_W:0] ONE = 1;

  state_e            state_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   len_d;
  logic [DATA_W-1:0] din_q;
  logic [ADDR_W-1:0] addr_q;
  logic              ready_q;
  logic              active_q;
  logic              addrload_q;
  logic              prload_q;
  logic              done_q;
  logic              xfer;

  assign xfer = bus.InValid && ready_q;

  // Length byte uses its low ADDR_W bits; zero stands for a full RAM.
  always_comb begin
    len_d = {1'b0, bus.InData[ADDR_W-1:0]};
    if (bus.InData[ADDR_W-1:0] == '0) len_d = {1'b1, {ADDR_W{1'b0}}};
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [CKSUM_W-1:0] sum;
  logic               error_q;

  prog_loader_cksum #(.DATA_W(DATA_W)) u_cksum (
    .clk_i  (Clock),
    .rst_ni (Reset),
    .clr_i  ((state_q == GETLEN) && xfer),
    .add_i  ((state_q == GETBYTE) && xfer),
    .data_i (bus.InData),
    .sum_o  (sum)
  );
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      din_q      <= '0;
      addr_q     <= '0;
      ready_q    <= 1'b0;
      active_q   <= 1'b0;
      addrload_q <= 1'b0;
      prload_q   <= 1'b0;
      done_q     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      error_q    <= 1'b0;
`endif
    end else begin
      addrload_q <= 1'b0;
      prload_q   <= 1'b0;
      case (state_q)
        IDLE: if (bus.Start) begin
          state_q  <= GETLEN;
          ready_q  <= 1'b1;
          active_q <= 1'b1;
        end
        GETLEN: if (xfer) begin
          len_q   <= len_d;
          cnt_q   <= '0;
          state_q <= GETBYTE;
        end
        GETBYTE: if (xfer) begin
          din_q      <= bus.InData;
          addr_q     <= cnt_q[ADDR_W-1:0];
          addrload_q <= 1'b1;
          ready_q    <= 1'b0;
          state_q    <= SETADDR;
        end
        SETADDR: begin
          prload_q <= 1'b1;
          state_q  <= WRITE;
        end
        WRITE: if (cnt_q == len_q - ONE) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          ready_q  <= 1'b1;
          state_q  <= CHECK;
`else
          active_q <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= DONE;
`endif
        end else begin
          cnt_q   <= cnt_q + ONE;
          ready_q <= 1'b1;
          state_q <= GETBYTE;
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        // Bytes plus trailer must sum to zero modulo 256.
        CHECK: if (xfer) begin
          error_q  <= (sum + CKSUM_W'(bus.InData)) != '0;
          ready_q  <= 1'b0;
          active_q <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
`endif
        DONE: if (!bus.Start) begin
          done_q  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
          error_q <= 1'b0;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.InReady   = ready_q;
  assign bus.programEn = active_q;
  assign bus.Busy      = active_q;
  assign bus.AddrSel   = addr_q;
  assign bus.Addrload  = addrload_q;
  assign bus.PRload    = prload_q;
  assign bus.Din       = din_q;
  assign bus.Done      = done_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign bus.Error     = error_q;
`else
  assign bus.Error     = 1'b0;
`endif
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: loads, gapped valid, start handling, async reset, optional checksum.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int AW = ADDR_W_DEF;
  localparam int DW = DATA_W_DEF;

  logic   Clock = 1'b0;
  logic   Reset = 1'b0;
  state_e dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic [DW-1:0]    vec[$];

  prog_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  prog_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every PRload pulse must match the head of exp_q; strobes never overlap.
  always @(negedge Clock) begin
    if (Reset && (bus.Addrload || bus.PRload))
      chk("strobe_overlap", 32'(bus.Addrload && bus.PRload), 32'd0);
    if (Reset && bus.PRload) begin
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("write_addr_data", 32'({bus.AddrSel, bus.Din}), 32'(exp_q.pop_front()));
    end
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    chk({tag, "_flags"}, 32'({bus.InReady, bus.programEn, bus.Addrload, bus.PRload,
                              bus.Busy, bus.Done, bus.Error}), 32'd0);
    chk({tag, "_addr"}, 32'(bus.AddrSel), 32'd0);
    chk({tag, "_din"}, 32'(bus.Din), 32'd0);
  endtask

  // Driver: present a byte after gap idle cycles, hold until accepted.
  task automatic send_byte(input logic [DW-1:0] b, input int gap);
    bit ok = 1'b0;
    repeat (gap) @(negedge Clock);
    bus.InValid = 1'b1;
    bus.InData  = b;
    for (int k = 0; k < 50; k++) begin
      if (bus.InReady) begin
        @(posedge Clock);
        ok = 1'b1;
        break;
      end
      @(negedge Clock);
    end
    if (ok) @(negedge Clock);
    bus.InValid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic start_load();
    @(negedge Clock);
    bus.Start = 1'b1;
    @(negedge Clock);
    bus.Start = 1'b0;
    chk("start_state", 32'(dbg_state), 32'(GETLEN));
    chk("start_flags", 32'({bus.InReady, bus.programEn, bus.Busy, bus.Done}), 32'b1110);
  endtask

  task automatic finish_load(input logic exp_err);
    bit seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (bus.Done) begin
        seen = 1'b1;
        break;
      end
      @(negedge Clock);
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("done_state", 32'(dbg_state), 32'(DONE));
    chk("done_flags", 32'({bus.programEn, bus.Busy, bus.Done, bus.Error}), 32'({3'b001, exp_err}));
    chk("writes_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_load(input logic [DW-1:0] n_byte, input int gap);
    logic [7:0] sum = 8'd0;
    start_load();
    send_byte(n_byte, gap);
    for (int i = 0; i < vec.size(); i++) begin
      exp_q.push_back({AW'(i), vec[i]});
      sum = sum + 8'(vec[i]);
      send_byte(vec[i], gap);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(DW'(8'd0 - sum), gap);
`endif
    finish_load(1'b0);
    @(negedge Clock);
    chk("back_idle_state", 32'(dbg_state), 32'(IDLE));
    chk("back_idle_done", 32'(bus.Done), 32'd0);
  endtask

  initial begin
    bus.Start   = 1'b0;
    bus.InValid = 1'b0;
    bus.InData  = '0;

    // Reset
    repeat (2) @(negedge Clock);
    chk_idle("reset");
    Reset = 1'b1;
    @(negedge Clock);
    chk("idle_hold", 32'(dbg_state), 32'(IDLE));

    // Three-byte load with continuous valid
    vec = '{8'hA1, 8'hB2, 8'hC3};
    do_load(8'h03, 0);

    // Length 0 means the full 32-word RAM, data equals address
    vec.delete();
    for (int i = 0; i < 32; i++) vec.push_back(DW'(i));
    do_load(8'h00, 0);

    // Valid asserted only one cycle in three
    vec = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_load(8'h04, 2);

    // Start pulsed mid-load is ignored; Start held keeps DONE
    start_load();
    send_byte(8'h02, 0);
    exp_q.push_back({AW'(0), 8'h5A});
    exp_q.push_back({AW'(1), 8'h6B});
    send_byte(8'h5A, 0);
    for (int k = 0; k < 10 && dbg_state != GETBYTE; k++) @(negedge Clock);
    bus.Start = 1'b1;
    @(negedge Clock);
    chk("start_ignored_state", 32'(dbg_state), 32'(GETBYTE));
    chk("start_ignored_busy", 32'({bus.Busy, bus.Done}), 32'b10);
    send_byte(8'h6B, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h3B, 0);
`endif
    finish_load(1'b0);
    repeat (3) @(negedge Clock);
    chk("hold_done_state", 32'(dbg_state), 32'(DONE));
    chk("hold_done_flag", 32'(bus.Done), 32'd1);
    bus.Start = 1'b0;
    @(negedge Clock);
    chk("release_state", 32'(dbg_state), 32'(IDLE));
    chk("release_done", 32'(bus.Done), 32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Trailer D0 balances 10+20; D1 does not
    for (int t = 0; t < 2; t++) begin
      start_load();
      exp_q.push_back({AW'(0), 8'h10});
      exp_q.push_back({AW'(1), 8'h20});
      send_byte(8'h02, 0);
      send_byte(8'h10, 0);
      send_byte(8'h20, 0);
      send_byte((t == 0) ? 8'hD0 : 8'hD1, 0);
      finish_load(t == 1);
      @(negedge Clock);
      chk("cksum_exit_flags", 32'({bus.Done, bus.Error}), 32'd0);
    end
`endif

    // Asynchronous reset while in WRITE
    start_load();
    send_byte(8'h03, 0);
    exp_q.push_back({AW'(0), 8'h77});
    send_byte(8'h77, 0);
    for (int k = 0; k < 10 && !bus.PRload; k++) @(negedge Clock);
    chk("pre_reset_state", 32'(dbg_state), 32'(WRITE));
    #2 Reset = 1'b0;
    #1 chk_idle("async_reset");
    repeat (2) @(negedge Clock);
    chk_idle("reset_held");
    Reset = 1'b1;
    @(negedge Clock);
    chk("post_reset_state", 32'(dbg_state), 32'(IDLE));
    chk("post_reset_writes", 32'(exp_q.size()), 32'd0);

    repeat (2) @(negedge Clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
